// File: rtl/fetch_stage.sv
// IF stage of the 16-bit pipelined CPU: owns the PC, drives instruction-memory
// address and captures fetched instructions into the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter logic [15:0] NOP_INSTR   = 16'h0800
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_target_i,
  input  logic [15:0] instruction_i,
  output logic [15:0] pc_o,
  output logic [15:0] if_id_instr_o,
  output logic [15:0] if_id_pc_o,
  output logic        if_id_valid_o,
  output logic        booting_o
);

  typedef enum logic {BOOT, RUN} state_e;

  localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LAST =
    CNT_W'((BOOT_CYCLES == 0) ? 0 : BOOT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      pc_q, pc_d;
  logic [15:0]      instr_q, instr_d;
  logic [15:0]      ifpc_q, ifpc_d;
  logic             valid_q, valid_d;
  logic [15:0]      pc_inc;
  logic             boot_done;

  assign pc_inc    = pc_q + 16'd1;
  assign boot_done = (BOOT_CYCLES == 0) || (cnt_q == BOOT_LAST);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= BOOT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == BOOT) begin
      if (boot_done) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    booting_o = (state_q == BOOT);
  end

  // Branch outranks stall so a wrong-path instruction never reaches decode.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    valid_d = valid_q;
    if (state_q == BOOT) begin
      instr_d = NOP_INSTR;
      ifpc_d  = 16'h0000;
      valid_d = 1'b0;
    end else if (branch_taken_i) begin
      pc_d    = branch_target_i;
      instr_d = NOP_INSTR;
      ifpc_d  = 16'h0000;
      valid_d = 1'b0;
    end else if (stall_i) begin
      if (flush_i) begin
        instr_d = NOP_INSTR;
        ifpc_d  = 16'h0000;
        valid_d = 1'b0;
      end
    end else if (flush_i) begin
      pc_d    = pc_inc;
      instr_d = NOP_INSTR;
      ifpc_d  = 16'h0000;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_inc;
      instr_d = instruction_i;
      ifpc_d  = pc_inc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      ifpc_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o          = pc_q;
  assign if_id_instr_o = instr_q;
  assign if_id_pc_o    = ifpc_q;
  assign if_id_valid_o = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven bench for fetch_stage; expected records pass through a scoreboard
// queue and are compared one cycle after their stimulus is applied.
module tb_fetch_stage;

  typedef struct {
    string       name;
    logic        stall;
    logic        flush;
    logic        br;
    logic [15:0] tgt;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ifpc;
    logic        valid;
    logic        boot;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [15:0] branch_target_i = 16'h0000;
  logic [15:0] instruction_i;
  logic [15:0] pc_o;
  logic [15:0] if_id_instr_o;
  logic [15:0] if_id_pc_o;
  logic        if_id_valid_o;
  logic        booting_o;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs[$];
  vec_t sb[$];
  int   splitIdx;

  fetch_stage #(
    .RESET_PC(16'h0000),
    .BOOT_CYCLES(2),
    .NOP_INSTR(16'h0800)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .stall_i(stall_i),
    .flush_i(flush_i),
    .branch_taken_i(branch_taken_i),
    .branch_target_i(branch_target_i),
    .instruction_i(instruction_i),
    .pc_o(pc_o),
    .if_id_instr_o(if_id_instr_o),
    .if_id_pc_o(if_id_pc_o),
    .if_id_valid_o(if_id_valid_o),
    .booting_o(booting_o)
  );

  always #5 CLK = ~CLK;

  // Instruction memory: each word holds 16'h1000 + its address.
  assign instruction_i = 16'h1000 + pc_o;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard: got empty expected entry");
    end else begin
      e = sb.pop_front();
      checkField({e.name, ".pc"},    pc_o,                   e.pc);
      checkField({e.name, ".instr"}, if_id_instr_o,          e.instr);
      checkField({e.name, ".ifpc"},  if_id_pc_o,             e.ifpc);
      checkField({e.name, ".valid"}, {15'd0, if_id_valid_o}, {15'd0, e.valid});
      checkField({e.name, ".boot"},  {15'd0, booting_o},     {15'd0, e.boot});
    end
  endtask

  task automatic checkReset(input string tag);
    vec_t r;
    r.name = tag; r.stall = 0; r.flush = 0; r.br = 0; r.tgt = 0;
    r.pc = 16'h0000; r.instr = 16'h0800; r.ifpc = 16'h0000; r.valid = 0; r.boot = 1;
    sb.push_back(r);
    checkOutput();
  endtask

  task automatic applyStimulus(input vec_t v);
    stall_i         = v.stall;
    flush_i         = v.flush;
    branch_taken_i  = v.br;
    branch_target_i = v.tgt;
    sb.push_back(v);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic addVec(input string name, input logic s, input logic f, input logic b,
                        input logic [15:0] tgt, input logic [15:0] pc, input logic [15:0] instr,
                        input logic [15:0] ifpc, input logic valid, input logic boot);
    vec_t v;
    v.name = name; v.stall = s; v.flush = f; v.br = b; v.tgt = tgt;
    v.pc = pc; v.instr = instr; v.ifpc = ifpc; v.valid = valid; v.boot = boot;
    vecs.push_back(v);
  endtask

  initial begin
    //     name         s  f  b  tgt       pc        instr     ifpc      v  boot
    addVec("boot1",     0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 1);
    addVec("boot2",     0, 0, 0, 16'h0000, 16'h0000, 16'h0800, 16'h0000, 0, 0);
    addVec("seq0",      0, 0, 0, 16'h0000, 16'h0001, 16'h1000, 16'h0001, 1, 0);
    addVec("seq1",      0, 0, 0, 16'h0000, 16'h0002, 16'h1001, 16'h0002, 1, 0);
    addVec("seq2",      0, 0, 0, 16'h0000, 16'h0003, 16'h1002, 16'h0003, 1, 0);
    addVec("seq3",      0, 0, 0, 16'h0000, 16'h0004, 16'h1003, 16'h0004, 1, 0);
    addVec("seq4",      0, 0, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1, 0);
    addVec("stall1",    1, 0, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1, 0);
    addVec("stall2",    1, 0, 0, 16'h0000, 16'h0005, 16'h1004, 16'h0005, 1, 0);
    addVec("resume",    0, 0, 0, 16'h0000, 16'h0006, 16'h1005, 16'h0006, 1, 0);
    addVec("brStall",   1, 0, 1, 16'h0040, 16'h0040, 16'h0800, 16'h0000, 0, 0);
    addVec("brTarget",  0, 0, 0, 16'h0000, 16'h0041, 16'h1040, 16'h0041, 1, 0);
    addVec("flush",     0, 1, 0, 16'h0000, 16'h0042, 16'h0800, 16'h0000, 0, 0);
    addVec("postFlush", 0, 0, 0, 16'h0000, 16'h0043, 16'h1042, 16'h0043, 1, 0);
    addVec("stallFl",   1, 1, 0, 16'h0000, 16'h0043, 16'h0800, 16'h0000, 0, 0);
    addVec("postStFl",  0, 0, 0, 16'h0000, 16'h0044, 16'h1043, 16'h0044, 1, 0);
    addVec("brFFFF",    0, 0, 1, 16'hFFFF, 16'hFFFF, 16'h0800, 16'h0000, 0, 0);
    addVec("wrap",      0, 0, 0, 16'h0000, 16'h0000, 16'h0FFF, 16'h0000, 1, 0);
    addVec("postWrap",  0, 0, 0, 16'h0000, 16'h0001, 16'h1000, 16'h0001, 1, 0);
    addVec("brFlush",   0, 1, 1, 16'h0010, 16'h0010, 16'h0800, 16'h0000, 0, 0);
    splitIdx = vecs.size();
    addVec("bootIgn1",  1, 1, 1, 16'h0030, 16'h0000, 16'h0800, 16'h0000, 0, 1);
    addVec("bootIgn2",  0, 0, 1, 16'h0030, 16'h0000, 16'h0800, 16'h0000, 0, 0);
    addVec("reSeq0",    0, 0, 0, 16'h0000, 16'h0001, 16'h1000, 16'h0001, 1, 0);
    addVec("reStall",   1, 0, 0, 16'h0000, 16'h0001, 16'h1000, 16'h0001, 1, 0);
    addVec("reSeq1",    0, 0, 0, 16'h0000, 16'h0002, 16'h1001, 16'h0002, 1, 0);

    // Power-on reset held low for three clock edges.
    #2 RST = 1'b0;
    #1 checkReset("rstAsync");
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK);
      #1 checkReset($sformatf("rstHold%0d", i));
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;

    for (int i = 0; i < splitIdx; i++) begin
      applyStimulus(vecs[i]);
    end

    // Reset asserted mid-cycle must take effect without waiting for a clock.
    #2 RST = 1'b0;
    #1 checkReset("rstMidRun");
    @(posedge CLK);
    #1 checkReset("rstMidHold");
    @(negedge CLK);
    RST = 1'b1;
    #1;

    for (int i = splitIdx; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
